// File: rtl/iob_cache_read_channel_axi_pkg.sv
// iob_cache_read_channel_axi_pkg: FSM states and AXI constants shared by the read channel
package iob_cache_read_channel_axi_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [3:0] AXI_ARCACHE    = 4'b0011;
   localparam logic [2:0] AXI_ARPROT     = 3'b010;
endpackage

// File: rtl/iob_cache_read_channel_axi_if.sv
// iob_cache_read_channel_axi_if: AXI4 AR/R channel bundle between the cache and memory
interface iob_cache_read_channel_axi_if #(
   parameter int BE_ADDR_W = 32,
   parameter int BE_DATA_W = 32,
   parameter int AXI_ID_W  = 1
) ();
   logic                 arvalid;
   logic                 arready;
   logic [BE_ADDR_W-1:0] araddr;
   logic [7:0]           arlen;
   logic [2:0]           arsize;
   logic [1:0]           arburst;
   logic                 arlock;
   logic [3:0]           arcache;
   logic [2:0]           arprot;
   logic [3:0]           arqos;
   logic [AXI_ID_W-1:0]  arid;
   logic                 rvalid;
   logic                 rready;
   logic [BE_DATA_W-1:0] rdata;
   logic [1:0]           rresp;
   logic                 rlast;
   modport master (
      output arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid, rready,
      input  arready, rvalid, rdata, rresp, rlast
   );
   modport slave (
      input  arvalid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid, rready,
      output arready, rvalid, rdata, rresp, rlast
   );
endinterface

// File: rtl/iob_cache_read_channel_axi.sv
// iob_cache_read_channel_axi: fetches one cache line as a single AXI INCR burst, retrying on error
module iob_cache_read_channel_axi
   import iob_cache_read_channel_axi_pkg::*;
#(
   parameter int FE_ADDR_W  = 32,
   parameter int FE_DATA_W  = 32,
   parameter int BE_ADDR_W  = 32,
   parameter int BE_DATA_W  = 32,
   parameter int WORD_OFF_W = 3,
   parameter int AXI_ID_W   = 1,
   parameter int AXI_ID     = 0,
   localparam int BE_BYTE_W  = $clog2(BE_DATA_W/8),
   localparam int LINE2MEM_W = WORD_OFF_W - $clog2(BE_DATA_W/FE_DATA_W),
   localparam int RA_W       = (LINE2MEM_W > 0) ? LINE2MEM_W : 1,
   localparam int LA_W       = FE_ADDR_W - BE_BYTE_W - LINE2MEM_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 replace_valid,
   input  logic [LA_W-1:0]      replace_addr,
   output logic                 replace_ready,
   output logic                 read_valid,
   output logic [RA_W-1:0]      read_addr,
   output logic [BE_DATA_W-1:0] read_rdata,
   iob_cache_read_channel_axi_if.master axi
);
   state_t                state;
   logic [LA_W-1:0]       addr_q;
   logic [RA_W-1:0]       cnt;
   logic                  err;
   logic                  err_n;
   logic [RA_W-1:0]       cnt_n;
   logic [FE_ADDR_W-1:0]  line_addr;
   // single-beat lines keep the counter pinned at zero
   assign err_n      = err | (axi.rresp != AXI_RESP_OKAY);
   assign cnt_n      = (LINE2MEM_W == 0) ? '0 : cnt + RA_W'(1);
   assign line_addr  = {addr_q, {(LINE2MEM_W+BE_BYTE_W){1'b0}}};
   assign read_valid = axi.rvalid & (state == DATA);
   assign read_addr  = cnt;
   assign read_rdata = axi.rdata;
   assign axi.araddr  = BE_ADDR_W'(line_addr);
   assign axi.arlen   = 8'((2**LINE2MEM_W) - 1);
   assign axi.arsize  = 3'(BE_BYTE_W);
   assign axi.arburst = AXI_BURST_INCR;
   assign axi.arlock  = 1'b0;
   assign axi.arcache = AXI_ARCACHE;
   assign axi.arprot  = AXI_ARPROT;
   assign axi.arqos   = 4'd0;
   assign axi.arid    = AXI_ID_W'(AXI_ID);
   // fill FSM: request latch, address phase, data phase with retry on any non-OKAY beat
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         replace_ready <= 1'b1;
         axi.arvalid   <= 1'b0;
         axi.rready    <= 1'b0;
         cnt           <= '0;
         err           <= 1'b0;
         addr_q        <= '0;
      end else begin
         unique case (state)
            IDLE: if (replace_valid) begin
               addr_q        <= replace_addr;
               cnt           <= '0;
               err           <= 1'b0;
               state         <= ADDR;
               replace_ready <= 1'b0;
               axi.arvalid   <= 1'b1;
            end
            ADDR: if (axi.arready) begin
               axi.arvalid <= 1'b0;
               axi.rready  <= 1'b1;
               state       <= DATA;
            end
            DATA: if (axi.rvalid) begin
               cnt <= cnt_n;
               err <= err_n;
               if (axi.rlast) begin
                  axi.rready <= 1'b0;
                  if (err_n) begin
                     state       <= ADDR;
                     axi.arvalid <= 1'b1;
                     cnt         <= '0;
                     err         <= 1'b0;
                  end else begin
                     state         <= IDLE;
                     replace_ready <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iob_cache_read_channel_axi.sv
// tb_iob_cache_read_channel_axi: scoreboard bench for the line-fill read channel
module tb_iob_cache_read_channel_axi;
   typedef struct packed {logic [2:0] a; logic [31:0] d;} exp_t;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;
   int passed = 0;
   int total = 0;
   int writes0 = 0;
   int writes1 = 0;
   int ar_hs0 = 0;
   exp_t q0[$];
   logic [255:0] q1[$];
   exp_t e0;
   logic [255:0] e1;
   logic        rv0, rr0, rdv0;
   logic [26:0] ra0;
   logic [2:0]  rda0;
   logic [31:0] rdd0;
   logic         rv1, rr1, rdv1;
   logic [26:0]  ra1;
   logic [0:0]   rda1;
   logic [255:0] rdd1;
   iob_cache_read_channel_axi_if #(.BE_ADDR_W(32), .BE_DATA_W(32), .AXI_ID_W(1)) ax0 ();
   iob_cache_read_channel_axi_if #(.BE_ADDR_W(32), .BE_DATA_W(256), .AXI_ID_W(1)) ax1 ();
   iob_cache_read_channel_axi dut0 (
      .clk(clk), .reset(reset), .replace_valid(rv0), .replace_addr(ra0), .replace_ready(rr0),
      .read_valid(rdv0), .read_addr(rda0), .read_rdata(rdd0), .axi(ax0)
   );
   iob_cache_read_channel_axi #(.BE_DATA_W(256)) dut1 (
      .clk(clk), .reset(reset), .replace_valid(rv1), .replace_addr(ra1), .replace_ready(rr1),
      .read_valid(rdv1), .read_addr(rda1), .read_rdata(rdd1), .axi(ax1)
   );
   // scoreboard for the 32-bit instance: every line write must match the oldest driven beat
   always @(negedge clk) begin
      #4;
      if (ax0.arvalid && ax0.arready) ar_hs0++;
      if (rdv0) begin
         writes0++;
         total++;
         if (q0.size() == 0) $display("FAIL sb0_extra got write addr=%0d data=%h, required no write", rda0, rdd0);
         else begin
            e0 = q0.pop_front();
            if (rda0 !== e0.a || rdd0 !== e0.d) $display("FAIL sb0_beat got addr=%0d data=%h, required addr=%0d data=%h", rda0, rdd0, e0.a, e0.d);
            else passed++;
         end
      end
   end
   // scoreboard for the 256-bit single-beat instance
   always @(negedge clk) begin
      #4;
      if (rdv1) begin
         writes1++;
         total++;
         if (q1.size() == 0) $display("FAIL sb1_extra got write addr=%0d, required no write", rda1);
         else begin
            e1 = q1.pop_front();
            if (rda1 !== 1'b0 || rdd1 !== e1) $display("FAIL sb1_beat got addr=%0d data=%h, required addr=0 data=%h", rda1, rdd1, e1);
            else passed++;
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog got timeout, required completion");
      $fatal(1);
   end
   task automatic test_reset;
      reset = 1'b1;
      rv0 = 1'b0; ra0 = '0; rv1 = 1'b0; ra1 = '0;
      ax0.arready = 1'b0; ax0.rvalid = 1'b0; ax0.rdata = '0; ax0.rresp = 2'b00; ax0.rlast = 1'b0;
      ax1.arready = 1'b0; ax1.rvalid = 1'b0; ax1.rdata = '0; ax1.rresp = 2'b00; ax1.rlast = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (rr0 !== 1'b1) $display("FAIL rst_ready got %b, required 1", rr0); else passed++;
      total++; if (ax0.arvalid !== 1'b0) $display("FAIL rst_arvalid got %b, required 0", ax0.arvalid); else passed++;
      total++; if (ax0.rready !== 1'b0) $display("FAIL rst_rready got %b, required 0", ax0.rready); else passed++;
      total++; if (rdv0 !== 1'b0) $display("FAIL rst_read_valid got %b, required 0", rdv0); else passed++;
      total++; if (rr1 !== 1'b1) $display("FAIL rst_ready1 got %b, required 1", rr1); else passed++;
      reset = 1'b0;
   endtask
   task automatic request0(input logic [26:0] a);
      @(negedge clk);
      rv0 = 1'b1; ra0 = a;
      @(negedge clk);
      rv0 = 1'b0;
      total++;
      if ({rr0, ax0.arvalid} !== 2'b01) $display("FAIL req_latency got ready,arvalid=%b, required 01", {rr0, ax0.arvalid});
      else passed++;
   endtask
   task automatic ar0(input logic [31:0] exp_a, input int delay);
      for (int i = 0; i < 20 && ax0.arvalid !== 1'b1; i++) @(negedge clk);
      total++; if (ax0.arvalid !== 1'b1) $display("FAIL ar_wait got arvalid=%b, required 1", ax0.arvalid); else passed++;
      total++;
      if ({ax0.araddr, ax0.arlen, ax0.arsize, ax0.arburst, ax0.arcache, ax0.arprot, ax0.arlock, ax0.arqos, ax0.arid}
          !== {exp_a, 8'd7, 3'd2, 2'b01, 4'b0011, 3'b010, 1'b0, 4'd0, 1'b0})
         $display("FAIL ar_fields got addr=%h len=%0d size=%0d burst=%b cache=%b prot=%b, required addr=%h len=7 size=2 burst=01 cache=0011 prot=010",
                  ax0.araddr, ax0.arlen, ax0.arsize, ax0.arburst, ax0.arcache, ax0.arprot, exp_a);
      else passed++;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         total++;
         if (ax0.arvalid !== 1'b1 || ax0.araddr !== exp_a) $display("FAIL ar_stable got arvalid=%b addr=%h, required 1 %h", ax0.arvalid, ax0.araddr, exp_a);
         else passed++;
      end
      ax0.arready = 1'b1;
      @(negedge clk);
      ax0.arready = 1'b0;
      total++;
      if ({ax0.arvalid, ax0.rready} !== 2'b01) $display("FAIL ar_done got arvalid,rready=%b, required 01", {ax0.arvalid, ax0.rready});
      else passed++;
   endtask
   task automatic r0(input int gap, input int err_beat, input int nb);
      for (int i = 0; i < nb; i++) begin
         repeat (gap) @(negedge clk);
         total++; if (ax0.rready !== 1'b1) $display("FAIL r_ready got %b, required 1", ax0.rready); else passed++;
         ax0.rvalid = 1'b1;
         ax0.rdata = $urandom;
         ax0.rresp = (i == err_beat) ? 2'b10 : 2'b00;
         ax0.rlast = (i == 7);
         q0.push_back({3'(i), ax0.rdata});
         @(negedge clk);
         ax0.rvalid = 1'b0; ax0.rlast = 1'b0; ax0.rresp = 2'b00;
      end
   endtask
   task automatic done0(input string name, input int w, input int exp_w);
      total++;
      if ({rr0, ax0.rready, ax0.arvalid} !== 3'b100) $display("FAIL %s_idle got ready,rready,arvalid=%b, required 100", name, {rr0, ax0.rready, ax0.arvalid});
      else passed++;
      total++;
      if (writes0 - w != exp_w || q0.size() != 0) $display("FAIL %s_writes got %0d (left %0d), required %0d", name, writes0 - w, q0.size(), exp_w);
      else passed++;
   endtask
   task automatic test_basic;
      int w = writes0;
      request0(27'h123456);
      ar0({27'h123456, 5'b0}, 0);
      r0(0, -1, 8);
      done0("basic", w, 8);
   endtask
   task automatic test_ar_stall;
      int w = writes0;
      int hs = ar_hs0;
      request0(27'h0ABCDE);
      ar0({27'h0ABCDE, 5'b0}, 5);
      r0(0, -1, 8);
      done0("stall", w, 8);
      total++; if (ar_hs0 - hs != 1) $display("FAIL stall_hs got %0d, required 1", ar_hs0 - hs); else passed++;
   endtask
   task automatic test_gap;
      int w = writes0;
      request0(27'h7FFFFFF);
      ar0({27'h7FFFFFF, 5'b0}, 0);
      r0(2, -1, 8);
      done0("gap", w, 8);
   endtask
   task automatic test_retry;
      int w = writes0;
      int hs = ar_hs0;
      request0(27'h1234567);
      ar0({27'h1234567, 5'b0}, 0);
      r0(0, 3, 8);
      total++;
      if ({rr0, ax0.arvalid} !== 2'b01) $display("FAIL retry_ar got ready,arvalid=%b, required 01", {rr0, ax0.arvalid});
      else passed++;
      ar0({27'h1234567, 5'b0}, 0);
      r0(0, -1, 8);
      done0("retry", w, 16);
      total++; if (ar_hs0 - hs != 2) $display("FAIL retry_hs got %0d, required 2", ar_hs0 - hs); else passed++;
   endtask
   task automatic test_async_reset;
      int w;
      request0(27'h0055AA);
      ar0({27'h0055AA, 5'b0}, 0);
      r0(0, -1, 4);
      ax0.rvalid = 1'b1;
      ax0.rdata = $urandom;
      #2 reset = 1'b1;
      #1;
      total++;
      if ({ax0.arvalid, ax0.rready, rr0, rdv0} !== 4'b0010) $display("FAIL areset_now got arvalid,rready,ready,rvalid=%b, required 0010", {ax0.arvalid, ax0.rready, rr0, rdv0});
      else passed++;
      @(negedge clk);
      total++;
      if ({ax0.arvalid, ax0.rready, rr0} !== 3'b001) $display("FAIL areset_edge got arvalid,rready,ready=%b, required 001", {ax0.arvalid, ax0.rready, rr0});
      else passed++;
      reset = 1'b0;
      ax0.rvalid = 1'b0;
      w = writes0;
      request0(27'h00AA55);
      ar0({27'h00AA55, 5'b0}, 0);
      r0(0, -1, 8);
      done0("after_reset", w, 8);
   endtask
   task automatic test_wide;
      int w = writes1;
      @(negedge clk);
      rv1 = 1'b1; ra1 = 27'h2ABCDEF;
      @(negedge clk);
      rv1 = 1'b0;
      total++;
      if ({ax1.arvalid, ax1.araddr, ax1.arlen, ax1.arsize, ax1.arburst} !== {1'b1, 27'h2ABCDEF, 5'b0, 8'd0, 3'd5, 2'b01})
         $display("FAIL wide_ar got arvalid=%b addr=%h len=%0d size=%0d, required 1 %h 0 5", ax1.arvalid, ax1.araddr, ax1.arlen, ax1.arsize, {27'h2ABCDEF, 5'b0});
      else passed++;
      ax1.arready = 1'b1;
      @(negedge clk);
      ax1.arready = 1'b0;
      total++; if (ax1.rready !== 1'b1) $display("FAIL wide_rready got %b, required 1", ax1.rready); else passed++;
      for (int i = 0; i < 8; i++) ax1.rdata[i*32 +: 32] = $urandom;
      ax1.rvalid = 1'b1; ax1.rlast = 1'b1;
      q1.push_back(ax1.rdata);
      @(negedge clk);
      ax1.rvalid = 1'b0; ax1.rlast = 1'b0;
      total++;
      if (rr1 !== 1'b1 || writes1 - w != 1 || q1.size() != 0) $display("FAIL wide_done got ready=%b writes=%0d, required 1 1", rr1, writes1 - w);
      else passed++;
   endtask
   initial begin
      test_reset();
      test_basic();
      test_ar_stall();
      test_gap();
      test_retry();
      test_async_reset();
      test_wide();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
